// File: rtl/timer_periph.sv
// Memory-mapped 32-bit timer: prescaled up-counter with compare match,
// optional auto-reload and a level interrupt. Register reads are combinational.
module timer_periph #(
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_vld,
    input  logic        i_wren,
    input  logic [3:0]  i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_bmask,
    output logic [31:0] o_rdata,
    output logic        o_irq
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NBYTES   = DATA_W / 8;
    localparam int unsigned PSC_LSB  = 8;
    localparam logic [1:0]  REG_CTRL   = 2'd0;
    localparam logic [1:0]  REG_COUNT  = 2'd1;
    localparam logic [1:0]  REG_CMP    = 2'd2;
    localparam logic [1:0]  REG_STATUS = 2'd3;

    logic                  en_q, en_d;
    logic                  auto_q, auto_d;
    logic                  irq_en_q, irq_en_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] psc_cnt_q, psc_cnt_d;
    logic [DATA_W-1:0]     count_q, count_d;
    logic [DATA_W-1:0]     cmp_q, cmp_d;
    logic                  match_q, match_d;
    logic                  irq_q, irq_d;

    logic [DATA_W-1:0]     ctrl_img;
    logic [DATA_W-1:0]     ctrl_mask;
    logic [DATA_W-1:0]     ctrl_wr;
    logic                  wr_en;
    logic                  tick;
    logic                  hit;
    logic                  unused_addr_bits;
    logic                  unused_ctrl_bits;

    // Byte-enable merge of store data into an existing register image.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [NBYTES-1:0] be
    );
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int b = 0; b < int'(NBYTES); b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    always_comb begin
        ctrl_img                       = '0;
        ctrl_img[0]                    = en_q;
        ctrl_img[1]                    = auto_q;
        ctrl_img[2]                    = irq_en_q;
        ctrl_img[PSC_LSB +: PRESCALE_W] = prescale_q;
    end

    always_comb begin
        ctrl_mask                        = '0;
        ctrl_mask[2:0]                   = 3'b111;
        ctrl_mask[PSC_LSB +: PRESCALE_W] = '1;
    end

    assign ctrl_wr = merge_bytes(ctrl_img, i_wdata, i_bmask);
    assign wr_en   = i_vld & i_wren;
    assign tick    = en_q && (psc_cnt_q == prescale_q);
    assign hit     = tick && (count_q == cmp_q);

    // Only word-aligned decode is used; reserved CTRL write bits are dropped.
    assign unused_addr_bits = ^i_addr[1:0];
    assign unused_ctrl_bits = ^(ctrl_wr & ~ctrl_mask);

    // Combinational load path; forced to zero outside a valid load or in reset.
    always_comb begin
        o_rdata = '0;
        if (i_rst_n && i_vld && !i_wren) begin
            unique case (i_addr[3:2])
                REG_CTRL:   o_rdata = ctrl_img;
                REG_COUNT:  o_rdata = count_q;
                REG_CMP:    o_rdata = cmp_q;
                REG_STATUS: o_rdata = {{(DATA_W-1){1'b0}}, match_q};
                default:    o_rdata = '0;
            endcase
        end
    end

    // Next-state: tick/match from pre-write state, then software writes, then match set.
    always_comb begin
        en_d       = en_q;
        auto_d     = auto_q;
        irq_en_d   = irq_en_q;
        prescale_d = prescale_q;
        cmp_d      = cmp_q;
        match_d    = match_q;
        irq_d      = match_q & irq_en_q;
        count_d    = count_q;
        psc_cnt_d  = '0;

        if (en_q && !tick) begin
            psc_cnt_d = psc_cnt_q + PRESCALE_W'(1);
        end

        if (tick) begin
            count_d = (hit && auto_q) ? '0 : count_q + DATA_W'(1);
        end

        if (wr_en) begin
            unique case (i_addr[3:2])
                REG_CTRL: begin
                    en_d       = ctrl_wr[0];
                    auto_d     = ctrl_wr[1];
                    irq_en_d   = ctrl_wr[2];
                    prescale_d = ctrl_wr[PSC_LSB +: PRESCALE_W];
                    if ((prescale_d != prescale_q) || (en_q && !en_d)) begin
                        psc_cnt_d = '0;
                    end
                end
                REG_COUNT:  count_d = merge_bytes(count_q, i_wdata, i_bmask);
                REG_CMP:    cmp_d   = merge_bytes(cmp_q, i_wdata, i_bmask);
                REG_STATUS: begin
                    if (i_bmask[0] && i_wdata[0]) begin
                        match_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        if (hit) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            prescale_q <= '0;
            psc_cnt_q  <= '0;
            count_q    <= '0;
            cmp_q      <= '0;
            match_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            en_q       <= en_d;
            auto_q     <= auto_d;
            irq_en_q   <= irq_en_d;
            prescale_q <= prescale_d;
            psc_cnt_q  <= psc_cnt_d;
            count_q    <= count_d;
            cmp_q      <= cmp_d;
            match_q    <= match_d;
            irq_q      <= irq_d;
        end
    end

    assign o_irq = irq_q;

endmodule

// File: doc/timer_periph.md
TIMER_PERIPH -- requirements
Module: timer_periph

Interface
REQ-001 Parameter: PRESCALE_W, 8, width of the CTRL.PRESCALE field and of the internal prescale counter.
REQ-002 Port: i_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port: i_rst_n  in  1  reset, synchronous and active-low.
REQ-004 Port: i_vld  in  1  timer window selected by LSU decode (address in TIMER_BASE_ADDR..+15 and access valid).
REQ-005 Port: i_wren  in  1  1 = store, 0 = load; meaningful only when i_vld=1.
REQ-006 Port: i_addr  in  4  byte offset within the window; only i_addr[3:2] is decoded, and i_addr[1:0] is ignored.
REQ-007 Port: i_wdata  in  32  store data.
REQ-008 Port: i_bmask  in  4  byte enables for stores, where bit n enables byte n.
REQ-009 Port: o_rdata  out  32  load data.
REQ-010 Port: o_irq  out  1  timer interrupt, level.

Function
REQ-011 Register map SHALL be: 0x0 CTRL, 0x4 COUNT, 0x8 CMP, 0xC STATUS.
REQ-012 CTRL SHALL contain: bit0 EN; bit1 AUTO_RELOAD; bit2 IRQ_EN; bits[8+PRESCALE_W-1:8] PRESCALE; all other bits reserved, reading 0 and ignoring writes.
REQ-013 STATUS SHALL contain: bit0 MATCH; all other bits reserved, reading 0.
REQ-014 Reads SHALL be combinational: o_rdata SHALL equal the selected register when i_vld=1 and i_wren=0, and SHALL be 0 otherwise.
REQ-015 A write to CTRL, COUNT or CMP (i_vld=1, i_wren=1) SHALL update only the bytes enabled in i_bmask, taking effect at the next rising edge.
REQ-016 A STATUS write SHALL be write-1-to-clear: MATCH SHALL clear when i_bmask[0]=1 and i_wdata[0]=1; a written 0 SHALL have no effect.
REQ-017 Prescaler: while EN=1, the prescale counter SHALL count 0..PRESCALE and then wrap to 0, asserting an internal tick on the cycle its value equals PRESCALE.
REQ-018 PRESCALE=0 SHALL produce a tick every cycle; PRESCALE=N SHALL produce one tick every N+1 cycles.
REQ-019 While EN=0, the prescale counter SHALL be held at 0, COUNT SHALL hold its value, and no tick SHALL occur.
REQ-020 On a tick with COUNT != CMP, COUNT SHALL increment by 1, modulo 2^32 (0xFFFFFFFF wraps to 0x00000000).
REQ-021 On a tick with COUNT == CMP: MATCH SHALL be set to 1, and COUNT SHALL go to 0 if AUTO_RELOAD=1, otherwise to COUNT+1.
REQ-022 A COUNT write in the same cycle as a tick SHALL take priority: COUNT takes the written value and the increment is dropped.
REQ-023 The match check SHALL use the pre-write COUNT value, so MATCH can still set in that same cycle.
REQ-024 A STATUS clear in the same cycle as a match SHALL leave MATCH=1 (set wins).
REQ-025 A CTRL write that changes PRESCALE or clears EN SHALL reset the prescale counter to 0 at that edge.
REQ-026 A CMP write SHALL affect only match checks on later cycles; a tick in the same cycle SHALL compare against the old CMP.
REQ-027 o_irq SHALL be registered and SHALL equal MATCH & IRQ_EN as of the previous edge, so o_irq follows MATCH by one cycle.
REQ-028 An access with i_vld=0 SHALL have no effect on any register.

Reset
REQ-029 With i_rst_n=0 at a rising edge: CTRL, COUNT, CMP, MATCH, the prescale counter and o_irq SHALL all become 0.
REQ-030 Reset SHALL take priority over any access or tick in the same cycle.
REQ-031 Reset asserted mid-count SHALL discard any pending tick, and counting SHALL restart only after software sets EN again.
REQ-032 While reset is asserted, o_rdata SHALL follow REQ-014, reading all registers as 0.

Verification
REQ-033 Prescale: write CMP=0xFFFFFFFF, then CTRL=0x00000301 (EN=1, PRESCALE=3); after 12 cycles, a COUNT read SHALL return 3.
REQ-034 Auto-reload and interrupt:
- Stimulus: CMP=5, CTRL=0x7 (EN, AUTO_RELOAD, IRQ_EN, PRESCALE=0).
- Response: COUNT sequence 0,1,2,3,4,5,0; MATCH=1 on the edge after COUNT=5; o_irq=1 one cycle later.
- Then: STATUS write 0x1 SHALL return MATCH and o_irq to 0.
REQ-035 Wrap-around: write COUNT=0xFFFFFFFE, CMP=0x10, CTRL=0x1; COUNT SHALL read 0xFFFFFFFF, then 0x00000000, with no MATCH set.
REQ-036 Byte mask: with CMP=0, store 0xAABBCCDD to CMP with i_bmask=0b0101; a CMP read SHALL return 0x00BB00DD.
REQ-037 Collisions:
- COUNT write of 0x100 coincident with a tick: COUNT SHALL read 0x100.
- STATUS clear coincident with a match: MATCH SHALL read 1.
REQ-038 Reset mid-run: assert i_rst_n=0 for 1 cycle while EN=1 and COUNT=0x40; all registers SHALL read 0 afterwards and COUNT SHALL stay 0.
